// File: rtl/fp24_dot_seq.sv
// Dot-product sequencer: streams operand pairs through an external fp24
// multiplier/MAC, folds them into an accumulator and returns one result per command.
module fp24_dot_seq #(
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [LW-1:0] cmd_len,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [23:0]   op_a,
  input  logic [23:0]   op_b,
  output logic [23:0]   mac_a,
  output logic [23:0]   mac_b,
  output logic [23:0]   mac_c,
  input  logic [23:0]   mac_p,
  input  logic [23:0]   mac_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [23:0]   res_data,
  output logic          res_empty,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          sv_q, sv_d;
  logic          first_q, first_d;
  logic          empty_q, empty_d;
  logic [23:0]   acc_q, acc_d;
  logic [23:0]   sa_q, sa_d;
  logic [23:0]   sb_q, sb_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      first_q <= 1'b0;
      empty_q <= 1'b0;
      acc_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      first_q <= first_d;
      empty_q <= empty_d;
      acc_q   <= acc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sv_d      = 1'b0;
    first_d   = first_q;
    empty_d   = empty_q;
    acc_d     = acc_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;

    // fp24 has no zero, so the first product seeds the accumulator directly
    if (sv_q) begin
      acc_d   = first_q ? mac_p : mac_y;
      first_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_d   = cmd_len;
          first_d = 1'b1;
          empty_d = (cmd_len == '0);
          state_d = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        op_ready = (cnt_q != '0);
        if (op_valid && op_ready) begin
          sa_d  = op_a;
          sb_d  = op_b;
          sv_d  = 1'b1;
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!sv_q) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
          empty_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    mac_a     = sa_q;
    mac_b     = sb_q;
    mac_c     = acc_q;
    res_data  = (state_q == DONE && !empty_q) ? acc_q : 24'h000000;
    res_empty = (state_q == DONE) && empty_q;
    busy      = (state_q != IDLE);
  end

endmodule
